// File: rtl/type_pkg.sv
// Shared data-port types plus the store-buffer state and entry types.
package type_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  byte_en_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DRAIN
  } sb_state_t;

  typedef struct packed {
    addr_t    addr;
    data_t    wdata;
    byte_en_t byte_enable;
  } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// valid/ready request channel shared by the core data port and the dcache port.
interface store_buffer_if;
  import type_pkg::*;

  logic     valid;
  addr_t    addr;
  data_t    wdata;
  byte_en_t byte_enable;
  logic     ready;
  data_t    rdata;

  modport master (
    output valid, addr, wdata, byte_enable,
    input  ready, rdata
  );

  modport slave (
    input  valid, addr, wdata, byte_enable,
    output ready, rdata
  );
endinterface

// File: rtl/sb_fifo.sv
// Circular store buffer with wrap-bit pointers and a per-entry word-address hit vector.
module sb_fifo
  import type_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  sb_entry_t              push_entry,
  input  logic                   pop,
  input  logic [29:0]            hit_addr,
  output sb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0]       hit
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  sb_entry_t   r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_ptr[AW-1:0]] <= push_entry;
  end

  assign count = r_wr_ptr - r_rd_ptr;
  assign head  = r_mem[r_rd_ptr[AW-1:0]];

  // A slot is live when its distance from the head is below the occupancy.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      hit[i] = ({1'b0, AW'(AW'(i) - r_rd_ptr[AW-1:0])} < count) &&
               (r_mem[AW'(i)].addr[31:2] == hit_addr);
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write buffer between core data port and dcache; loads bypass
// buffered stores unless they alias one, in which case the buffer drains first.
module store_buffer
  import type_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  store_buffer_if.slave          core,
  store_buffer_if.master         cache,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  sb_state_t  r_state;
  logic       r_core_ready;
  logic       r_hit_wait;
  logic       r_cache_valid;
  sb_entry_t  r_cache_req;

  logic       w_is_store;
  logic       w_is_load;
  logic       w_store_acc;
  logic       w_load_ok;
  logic       w_pop;
  logic       w_load_done;
  logic [DEPTH-1:0] w_hit;
  logic [CW-1:0]    w_count;
  sb_entry_t  w_head;
  sb_entry_t  w_push_entry;

  assign w_is_store  = core.valid && (core.byte_enable != '0);
  assign w_is_load   = core.valid && (core.byte_enable == '0);
  assign w_store_acc = w_is_store && !r_core_ready && (w_count < CW'(DEPTH));
  // Once a load has aliased, it stays blocked until the whole buffer is empty.
  assign w_load_ok   = w_is_load && ((w_count == '0) || (!(|w_hit) && !r_hit_wait));
  assign w_pop       = (r_state == DRAIN) && cache.ready;
  assign w_load_done = (r_state == LOAD) && cache.ready;
  assign w_push_entry = '{addr: core.addr, wdata: core.wdata, byte_enable: core.byte_enable};

  sb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (w_store_acc),
    .push_entry (w_push_entry),
    .pop        (w_pop),
    .hit_addr   (core.addr[31:2]),
    .head       (w_head),
    .count      (w_count),
    .hit        (w_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= IDLE;
      r_core_ready  <= 1'b0;
      r_hit_wait    <= 1'b0;
      r_cache_valid <= 1'b0;
      r_cache_req   <= '0;
    end else begin
      r_core_ready <= w_store_acc;
      if (r_state == LOAD)
        r_hit_wait <= 1'b0;
      else if (w_is_load && (|w_hit))
        r_hit_wait <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_load_ok) begin
            r_state       <= LOAD;
            r_cache_valid <= 1'b1;
            r_cache_req   <= '{addr: core.addr, wdata: '0, byte_enable: '0};
          end else if (w_count != '0) begin
            r_state       <= DRAIN;
            r_cache_valid <= 1'b1;
            r_cache_req   <= w_head;
          end
        end
        LOAD, DRAIN: begin
          if (cache.ready) begin
            r_state       <= IDLE;
            r_cache_valid <= 1'b0;
            r_cache_req   <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cache.valid       = r_cache_valid;
  assign cache.addr        = r_cache_req.addr;
  assign cache.wdata       = r_cache_req.wdata;
  assign cache.byte_enable = r_cache_req.byte_enable;

  assign core.ready = r_core_ready | w_load_done;
  assign core.rdata = w_load_done ? cache.rdata : '0;

  assign count = w_count;
  assign empty = (w_count == '0) && (r_state == IDLE);

endmodule
